// File: rtl/design_variables.sv
// Shared defaults, packet layout and diagonal geometry for the wavefront score memory.
package design_variables;

   localparam int NUM_PU   = 16;
   localparam int NUM_PE   = 4;
   localparam int PKT_W    = 12;
   localparam int DIR_W    = 2;
   localparam int NUM_DIAG = 2*NUM_PU-1;

   localparam int DIAG_W  = $clog2(NUM_DIAG);
   localparam int PU_W    = $clog2(NUM_PU);
   localparam int PE_W    = $clog2(NUM_PE);
   localparam int CNT_W   = $clog2(NUM_PU*NUM_PU+1);
   localparam int SCORE_W = PKT_W-DIR_W;

   typedef struct packed {
      logic [SCORE_W-1:0] score;
      logic [DIR_W-1:0]   dir;
   } pkt_t;

   // Number of PU positions that exist on anti-diagonal d of a num_pu x num_pu grid.
   function automatic int diag_len(input int d, input int num_pu);
      if (d < num_pu)
         return d + 1;
      else if (d < 2*num_pu-1)
         return 2*num_pu-1-d;
      else
         return 0;
   endfunction

endpackage

// File: rtl/diag_score_memory_argmax.sv
// Combinational argmax over one diagonal write; ties resolve to the lowest pu,
// then the lowest pe.
module score_argmax #(
   parameter int NUM_PU  = design_variables::NUM_PU,
   parameter int NUM_PE  = design_variables::NUM_PE,
   parameter int SCORE_W = design_variables::SCORE_W,
   localparam int PU_W   = $clog2(NUM_PU),
   localparam int PE_W   = $clog2(NUM_PE)
) (
   input  logic [NUM_PU*NUM_PE*SCORE_W-1:0] scores,
   input  logic [NUM_PU*NUM_PE-1:0]         en,
   output logic [SCORE_W-1:0]               best_score,
   output logic [PU_W-1:0]                  best_pu,
   output logic [PE_W-1:0]                  best_pe,
   output logic                             any_valid
);

   // NOTE: every output gets a default before the loop so no path leaves a latch behind.
   always_comb begin
      best_score = '0;
      best_pu    = '0;
      best_pe    = '0;
      any_valid  = 1'b0;
      for (int pu = 0; pu < NUM_PU; pu++) begin
         for (int pe = 0; pe < NUM_PE; pe++) begin
            if (en[pu*NUM_PE+pe] &&
                (!any_valid || scores[(pu*NUM_PE+pe)*SCORE_W +: SCORE_W] > best_score)) begin
               best_score = scores[(pu*NUM_PE+pe)*SCORE_W +: SCORE_W];
               best_pu    = PU_W'(pu);
               best_pe    = PE_W'(pe);
               any_valid  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/diag_score_memory.sv
// Wavefront-organised score/direction store for the systolic aligner: masked
// diagonal writes, a registered read port, fill tracking and a running max.
module diag_score_memory
   import design_variables::diag_len;
#(
   parameter int NUM_PU    = design_variables::NUM_PU,
   parameter int NUM_PE    = design_variables::NUM_PE,
   parameter int PKT_W     = design_variables::PKT_W,
   parameter int DIR_W     = design_variables::DIR_W,
   localparam int NUM_DIAG = 2*NUM_PU-1,
   localparam int DIAG_W   = $clog2(NUM_DIAG),
   localparam int PU_W     = $clog2(NUM_PU),
   localparam int PE_W     = $clog2(NUM_PE),
   localparam int CNT_W    = $clog2(NUM_PU*NUM_PU+1),
   localparam int SCORE_W  = PKT_W-DIR_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           wr_valid,
   input  logic [DIAG_W-1:0]              wr_diag,
   input  logic [NUM_PU-1:0]              wr_pu_mask,
   input  logic [NUM_PU*NUM_PE*PKT_W-1:0] wr_data,
   output logic                           wr_err,
   input  logic                           rd_req,
   input  logic [DIAG_W-1:0]              rd_diag,
   input  logic [PU_W-1:0]                rd_pu,
   input  logic [PE_W-1:0]                rd_pe,
   output logic                           rd_valid,
   output logic [PKT_W-1:0]               rd_data,
   output logic                           rd_miss,
   output logic [CNT_W-1:0]               fill_count,
   output logic                           full,
   output logic [SCORE_W-1:0]             max_score,
   output logic [DIAG_W-1:0]              max_diag,
   output logic [PU_W-1:0]                max_pu,
   output logic [PE_W-1:0]                max_pe
);

   localparam int CELLS = NUM_DIAG*NUM_PU;
   localparam int IDX_W = $clog2(CELLS);
   localparam int ROW_W = NUM_PE*PKT_W;
   localparam int NSLOT = NUM_PU*NUM_PE;

   // One row per (diag, pu) cell holding all NUM_PE packets, flattened diag-major.
   logic [ROW_W-1:0]   mem_q [CELLS];
   logic [CELLS-1:0]   valid_q, valid_d;
   logic [CNT_W-1:0]   fill_count_q, fill_count_d;
   logic               full_q, full_d;
   logic               wr_err_q, wr_err_d;
   logic               rd_valid_q, rd_valid_d;
   logic [PKT_W-1:0]   rd_data_q, rd_data_d;
   logic               rd_miss_q, rd_miss_d;
   logic [SCORE_W-1:0] max_score_q, max_score_d;
   logic [DIAG_W-1:0]  max_diag_q, max_diag_d;
   logic [PU_W-1:0]    max_pu_q, max_pu_d;
   logic [PE_W-1:0]    max_pe_q, max_pe_d;
   logic               pend_valid_q, pend_valid_d;
   logic [SCORE_W-1:0] pend_score_q, pend_score_d;
   logic [DIAG_W-1:0]  pend_diag_q, pend_diag_d;
   logic [PU_W-1:0]    pend_pu_q, pend_pu_d;
   logic [PE_W-1:0]    pend_pe_q, pend_pe_d;

   logic               wr_accept;
   logic               wr_diag_ok;
   logic [NUM_PU-1:0]  legal_mask;
   logic [NUM_PU-1:0]  wr_en_mask;
   logic [CELLS-1:0]   wr_cell_en;
   logic [CNT_W-1:0]   new_cnt;

   logic               rd_idx_ok;
   logic [IDX_W-1:0]   rd_cell;
   logic [ROW_W-1:0]   rd_row;
   logic [PKT_W-1:0]   rd_pkt;
   logic               rd_hit;

   logic [NSLOT*SCORE_W-1:0] am_scores;
   logic [NSLOT-1:0]         am_en;
   logic [SCORE_W-1:0]       am_score;
   logic [PU_W-1:0]          am_pu;
   logic [PE_W-1:0]          am_pe;
   logic                     am_any;

   // Clear outranks a write, so a clear cycle never stores and never flags an error.
   always_comb begin
      wr_accept  = wr_valid && !clear;
      wr_diag_ok = ({1'b0, wr_diag} < (DIAG_W+1)'(NUM_DIAG));
      legal_mask = '0;
      for (int pu = 0; pu < NUM_PU; pu++)
         legal_mask[pu] = wr_diag_ok && (pu < diag_len(int'(wr_diag), NUM_PU));
      wr_en_mask = wr_accept ? (wr_pu_mask & legal_mask) : '0;
      wr_cell_en = '0;
      for (int d = 0; d < NUM_DIAG; d++)
         for (int pu = 0; pu < NUM_PU; pu++)
            wr_cell_en[d*NUM_PU+pu] = wr_en_mask[pu] && (wr_diag == DIAG_W'(d));
      wr_err_d = wr_accept && (!wr_diag_ok || |(wr_pu_mask & ~legal_mask));
   end

   always_comb begin
      new_cnt = '0;
      for (int c = 0; c < CELLS; c++)
         new_cnt = new_cnt + CNT_W'(wr_cell_en[c] & ~valid_q[c]);
      if (clear) begin
         valid_d      = '0;
         fill_count_d = '0;
      end else begin
         valid_d      = valid_q | wr_cell_en;
         fill_count_d = fill_count_q + new_cnt;
      end
      full_d = (fill_count_d == CNT_W'(NUM_PU*NUM_PU));
   end

   // Reads look at the pre-edge contents, which gives read-before-write and
   // pre-clear data for free.
   always_comb begin
      rd_idx_ok = ({1'b0, rd_diag} < (DIAG_W+1)'(NUM_DIAG)) &&
                  ({1'b0, rd_pu}   < (PU_W+1)'(NUM_PU)) &&
                  ({1'b0, rd_pe}   < (PE_W+1)'(NUM_PE));
      rd_cell   = rd_idx_ok ? IDX_W'(int'(rd_diag)*NUM_PU + int'(rd_pu)) : '0;
      rd_row    = mem_q[rd_cell];
      rd_pkt    = '0;
      for (int pe = 0; pe < NUM_PE; pe++)
         if (rd_pe == PE_W'(pe))
            rd_pkt = rd_row[pe*PKT_W +: PKT_W];
      rd_hit     = rd_idx_ok && valid_q[rd_cell];
      rd_valid_d = rd_req;
      rd_data_d  = rd_data_q;
      rd_miss_d  = rd_miss_q;
      if (rd_req) begin
         rd_data_d = rd_hit ? rd_pkt : '0;
         rd_miss_d = !rd_hit;
      end
   end

   always_comb begin
      am_scores = '0;
      am_en     = '0;
      for (int i = 0; i < NSLOT; i++) begin
         am_scores[i*SCORE_W +: SCORE_W] = wr_data[i*PKT_W+DIR_W +: SCORE_W];
         am_en[i]                        = wr_en_mask[i/NUM_PE];
      end
   end

   score_argmax #(
      .NUM_PU     (NUM_PU),
      .NUM_PE     (NUM_PE),
      .SCORE_W    (SCORE_W)
   ) u_argmax (
      .scores     (am_scores),
      .en         (am_en),
      .best_score (am_score),
      .best_pu    (am_pu),
      .best_pe    (am_pe),
      .any_valid  (am_any)
   );

   // Stage 1 captures this write's winner; stage 2 compares it against the
   // running max, which already includes the previous write's result.
   always_comb begin
      pend_valid_d = am_any;
      pend_score_d = am_score;
      pend_diag_d  = wr_diag;
      pend_pu_d    = am_pu;
      pend_pe_d    = am_pe;
      max_score_d  = max_score_q;
      max_diag_d   = max_diag_q;
      max_pu_d     = max_pu_q;
      max_pe_d     = max_pe_q;
      if (clear) begin
         pend_valid_d = 1'b0;
         max_score_d  = '0;
         max_diag_d   = '0;
         max_pu_d     = '0;
         max_pe_d     = '0;
      end else if (pend_valid_q && (pend_score_q > max_score_q)) begin
         max_score_d = pend_score_q;
         max_diag_d  = pend_diag_q;
         max_pu_d    = pend_pu_q;
         max_pe_d    = pend_pe_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= '0;
         fill_count_q <= '0;
         full_q       <= 1'b0;
         wr_err_q     <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         rd_miss_q    <= 1'b0;
         max_score_q  <= '0;
         max_diag_q   <= '0;
         max_pu_q     <= '0;
         max_pe_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_score_q <= '0;
         pend_diag_q  <= '0;
         pend_pu_q    <= '0;
         pend_pe_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         fill_count_q <= fill_count_d;
         full_q       <= full_d;
         wr_err_q     <= wr_err_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
         rd_miss_q    <= rd_miss_d;
         max_score_q  <= max_score_d;
         max_diag_q   <= max_diag_d;
         max_pu_q     <= max_pu_d;
         max_pe_q     <= max_pe_d;
         pend_valid_q <= pend_valid_d;
         pend_score_q <= pend_score_d;
         pend_diag_q  <= pend_diag_d;
         pend_pu_q    <= pend_pu_d;
         pend_pe_q    <= pend_pe_d;
      end
   end

   // NOTE: packet storage has no reset; the valid bits alone decide what a read may return.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CELLS; c++)
         if (wr_cell_en[c])
            mem_q[c] <= wr_data[(c % NUM_PU)*ROW_W +: ROW_W];
   end

   assign wr_err     = wr_err_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign rd_miss    = rd_miss_q;
   assign fill_count = fill_count_q;
   assign full       = full_q;
   assign max_score  = max_score_q;
   assign max_diag   = max_diag_q;
   assign max_pu     = max_pu_q;
   assign max_pe     = max_pe_q;

endmodule
